// File: rtl/betting_round_ctrl_pkg.sv
// Shared types for the betting round controller: action and FSM state
// encodings, the stack width, and the pay clamp helper.
package betting_round_ctrl_pkg;

   localparam int MAX_STACK_W = 8;

   typedef enum logic [1:0] {
      ACT_FOLD  = 2'd0,
      ACT_CALL  = 2'd1,
      ACT_RAISE = 2'd2
   } action_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_POST_SB,
      ST_POST_BB,
      ST_WAIT_ACT,
      ST_APPLY,
      ST_ADVANCE,
      ST_DONE
   } bet_state_t;

   // A seat can never pay more than it holds; the wanted amount carries one
   // extra bit so that call + raise cannot wrap before the clamp.
   function automatic logic [MAX_STACK_W-1:0] clamp_to_stack(
      input logic [MAX_STACK_W:0]   want,
      input logic [MAX_STACK_W-1:0] stack
   );
      if (want > {1'b0, stack}) return stack;
      return want[MAX_STACK_W-1:0];
   endfunction

endpackage

// File: rtl/betting_round_ctrl_next_seat_sel.sv
// Rotate-priority search: returns the first eligible seat strictly after
// start_seat, wrapping modulo N, with start_seat itself checked last.
// none_found is raised when no seat is eligible at all.
module next_seat_sel #(
   parameter int N      = 4,
   parameter int SEAT_W = 2
) (
   input  logic [N-1:0]      eligible,
   input  logic [SEAT_W-1:0] start_seat,
   output logic [SEAT_W-1:0] seat,
   output logic              none_found
);

   logic [SEAT_W-1:0] cand_idx [N];
   logic [N-1:0]      cand_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         logic [SEAT_W:0] sum;
         assign sum          = {1'b0, start_seat} + (SEAT_W+1)'(gi + 1);
         assign cand_idx[gi] = (sum >= (SEAT_W+1)'(N)) ? SEAT_W'(sum - (SEAT_W+1)'(N))
                                                       : sum[SEAT_W-1:0];
         assign cand_hit[gi] = eligible[cand_idx[gi]];
      end
   endgenerate

   // Walk candidates from farthest to nearest so the nearest hit wins.
   always_comb begin
      seat       = start_seat;
      none_found = 1'b1;
      for (int k = N - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            seat       = cand_idx[k];
            none_found = 1'b0;
         end
      end
   end

endmodule

// File: rtl/betting_round_ctrl.sv
// Betting round sequencer: takes one action at a time, computes the chips
// owed, strobes the addressed player, tracks pot / high bet / fold and
// all-in masks, and declares the round complete.
// Optional blind posting is enabled by defining BETTING_BLINDS_EN.
module betting_round_ctrl
   import betting_round_ctrl_pkg::*;
#(
   parameter int NUM_PLAYERS = 4,
   parameter int SEAT_W      = $clog2(NUM_PLAYERS),
   parameter int POT_W       = MAX_STACK_W + SEAT_W,
   parameter int SMALL_BLIND = 5,
   parameter int BIG_BLIND   = 10
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic                                    start,
   input  logic [SEAT_W-1:0]                       dealer_seat,
   input  logic                                    act_valid,
   output logic                                    act_ready,
   input  logic [1:0]                              act_type,
   input  logic [MAX_STACK_W-1:0]                  act_raise,
   input  logic [NUM_PLAYERS-1:0][MAX_STACK_W-1:0] player_stack,
   output logic [NUM_PLAYERS-1:0]                  player_en,
   output logic                                    player_make_bet,
   output logic [MAX_STACK_W-1:0]                  player_bet_amount,
   output logic [SEAT_W-1:0]                       active_seat,
   output logic [MAX_STACK_W-1:0]                  high_bet,
   output logic [POT_W-1:0]                        pot,
   output logic [NUM_PLAYERS-1:0]                  folded,
   output logic                                    round_done
);

   localparam int SW1 = MAX_STACK_W + 1;

`ifdef BETTING_BLINDS_EN
   localparam bit BLINDS_ON = 1'b1;
`else
   localparam bit BLINDS_ON = 1'b0;
`endif

   function automatic logic [SEAT_W-1:0] seat_plus(input logic [SEAT_W-1:0] s, input int k);
      int t;
      t = (int'(s) + k) % NUM_PLAYERS;
      return SEAT_W'(t);
   endfunction

   bet_state_t                state_q, state_d;
   logic [SEAT_W-1:0]         dealer_q, active_seat_q;
   logic [1:0]                act_type_q;
   logic [MAX_STACK_W-1:0]    act_raise_q, high_bet_q;
   logic [MAX_STACK_W-1:0]    committed_q [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0]    acted_q, allin_q, folded_q;
   logic [POT_W-1:0]          pot_q;

   // Heads-up: the dealer posts the small blind and acts first.
   logic [SEAT_W-1:0] sb_seat, bb_seat, first_seat;
   assign sb_seat    = (NUM_PLAYERS == 2) ? dealer_q : seat_plus(dealer_q, 1);
   assign bb_seat    = (NUM_PLAYERS == 2) ? seat_plus(dealer_q, 1) : seat_plus(dealer_q, 2);
   assign first_seat = !BLINDS_ON ? seat_plus(dealer_q, 1)
                     : ((NUM_PLAYERS == 2) ? dealer_q : seat_plus(dealer_q, 3));

   logic [SEAT_W-1:0]      bet_seat;
   logic [MAX_STACK_W-1:0] stack_cur, commit_cur, pay;
   logic [SW1-1:0]         call_amt, want, new_commit;
   logic [POT_W:0]         pot_sum;
   logic                   bet_state, is_fold, strobe, raises_high, goes_allin;

   // Pay computation for the seat being charged this cycle.
   always_comb begin
      bet_seat = active_seat_q;
      if (state_q == ST_POST_SB) bet_seat = sb_seat;
      if (state_q == ST_POST_BB) bet_seat = bb_seat;
      stack_cur  = player_stack[bet_seat];
      commit_cur = committed_q[bet_seat];
      call_amt   = SW1'(high_bet_q) - SW1'(commit_cur);
      bet_state  = (state_q == ST_APPLY) || (state_q == ST_POST_SB) || (state_q == ST_POST_BB);
      is_fold    = (state_q == ST_APPLY) && !((act_type_q == ACT_CALL) || (act_type_q == ACT_RAISE));
      want       = '0;
      case (state_q)
         ST_POST_SB: want = SW1'(SMALL_BLIND);
         ST_POST_BB: want = SW1'(BIG_BLIND);
         ST_APPLY: begin
            if (is_fold)
               want = '0;
            else if ((act_type_q == ACT_RAISE) && (act_raise_q != '0))
               want = call_amt + SW1'(act_raise_q);
            else
               want = call_amt;
         end
         default: want = '0;
      endcase
      pay         = clamp_to_stack(want, stack_cur);
      strobe      = bet_state && (pay != '0);
      new_commit  = SW1'(commit_cur) + SW1'(pay);
      raises_high = new_commit > SW1'(high_bet_q);
      goes_allin  = bet_state && !is_fold && (pay == stack_cur) && (stack_cur != '0);
      pot_sum     = (POT_W+1)'(pot_q) + (POT_W+1)'(pay);
   end

   // Round completion: one live seat left, or every seat still able to act
   // has acted and matched the high bet.
   logic [NUM_PLAYERS-1:0] eligible, seat_ok;
   logic [SEAT_W-1:0]      next_seat;
   logic                   none_found, round_over;
   int                     live_cnt;

   assign eligible = ~folded_q & ~allin_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_seat_ok
         assign seat_ok[gi] = !eligible[gi] || (acted_q[gi] && (committed_q[gi] == high_bet_q));
      end
   endgenerate

   // Count seats that have not folded and combine the completion terms.
   always_comb begin
      live_cnt = 0;
      for (int i = 0; i < NUM_PLAYERS; i++)
         if (!folded_q[i]) live_cnt = live_cnt + 1;
      round_over = (live_cnt == 1) || (&seat_ok) || none_found;
   end

   next_seat_sel #(.N(NUM_PLAYERS), .SEAT_W(SEAT_W)) u_next_seat (
      .eligible   (eligible),
      .start_seat (active_seat_q),
      .seat       (next_seat),
      .none_found (none_found)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_INIT;
         ST_INIT:     state_d = BLINDS_ON ? ST_POST_SB : ST_WAIT_ACT;
         ST_POST_SB:  state_d = ST_POST_BB;
         ST_POST_BB:  state_d = ST_WAIT_ACT;
         ST_WAIT_ACT: if (act_valid) state_d = ST_APPLY;
         ST_APPLY:    state_d = ST_ADVANCE;
         ST_ADVANCE:  state_d = round_over ? ST_DONE : ST_WAIT_ACT;
         ST_DONE:     if (start) state_d = ST_INIT;
         default:     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake, one-cycle player strobe, completion level.
   always_comb begin
      act_ready         = (state_q == ST_WAIT_ACT);
      round_done        = (state_q == ST_DONE);
      player_make_bet   = strobe;
      player_bet_amount = strobe ? pay : '0;
      player_en         = '0;
      if (strobe) player_en[bet_seat] = 1'b1;
   end

   // Round bookkeeping: masks, commitments, pot, high bet, turn pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dealer_q      <= '0;
         active_seat_q <= '0;
         act_type_q    <= '0;
         act_raise_q   <= '0;
         high_bet_q    <= '0;
         pot_q         <= '0;
         acted_q       <= '0;
         allin_q       <= '0;
         folded_q      <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) committed_q[i] <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (start) dealer_q <= dealer_seat;
            ST_INIT: begin
               high_bet_q    <= '0;
               pot_q         <= '0;
               acted_q       <= '0;
               allin_q       <= '0;
               folded_q      <= '0;
               active_seat_q <= first_seat;
               for (int i = 0; i < NUM_PLAYERS; i++) committed_q[i] <= '0;
            end
            ST_WAIT_ACT: if (act_valid) begin
               act_type_q  <= act_type;
               act_raise_q <= act_raise;
            end
            ST_POST_SB, ST_POST_BB, ST_APPLY: begin
               committed_q[bet_seat] <= new_commit[MAX_STACK_W-1:0];
               pot_q <= pot_sum[POT_W] ? '1 : pot_sum[POT_W-1:0];
               if (goes_allin) allin_q[bet_seat] <= 1'b1;
               if (raises_high) high_bet_q <= new_commit[MAX_STACK_W-1:0];
               // Blinds never count as having acted; a real raise (even a
               // short all-in) reopens action for everyone else.
               if (state_q == ST_APPLY) begin
                  if (is_fold) folded_q[bet_seat] <= 1'b1;
                  if (raises_high && !is_fold) begin
                     acted_q           <= '0;
                     acted_q[bet_seat] <= 1'b1;
                  end else begin
                     acted_q[bet_seat] <= 1'b1;
                  end
               end
            end
            ST_ADVANCE: if (!round_over) active_seat_q <= next_seat;
            default: ;
         endcase
      end
   end

   assign active_seat = active_seat_q;
   assign high_bet    = high_bet_q;
   assign pot         = pot_q;
   assign folded      = folded_q;

endmodule

// File: tb/tb_betting_round_ctrl.sv
// Directed bench for betting_round_ctrl (N=4): a table of actions with
// hand-computed strobes, pot and high bet, plus corner-case sequences.
module tb_betting_round_ctrl;
   import betting_round_ctrl_pkg::*;

   localparam int N  = 4;
   localparam int SW = 2;
   localparam int PW = MAX_STACK_W + SW;

   logic                          clk = 1'b0;
   logic                          reset_n = 1'b0;
   logic                          start = 1'b0;
   logic [SW-1:0]                 dealer_seat = '0;
   logic                          act_valid = 1'b0;
   logic                          act_ready;
   logic [1:0]                    act_type = '0;
   logic [MAX_STACK_W-1:0]        act_raise = '0;
   logic [N-1:0][MAX_STACK_W-1:0] player_stack;
   logic [N-1:0]                  player_en;
   logic                          player_make_bet;
   logic [MAX_STACK_W-1:0]        player_bet_amount;
   logic [SW-1:0]                 active_seat;
   logic [MAX_STACK_W-1:0]        high_bet;
   logic [PW-1:0]                 pot;
   logic [N-1:0]                  folded;
   logic                          round_done;

   int stacks [N];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) player_stack[i] = MAX_STACK_W'(stacks[i]);
   end

   betting_round_ctrl #(.NUM_PLAYERS(N)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .dealer_seat       (dealer_seat),
      .act_valid         (act_valid),
      .act_ready         (act_ready),
      .act_type          (act_type),
      .act_raise         (act_raise),
      .player_stack      (player_stack),
      .player_en         (player_en),
      .player_make_bet   (player_make_bet),
      .player_bet_amount (player_bet_amount),
      .active_seat       (active_seat),
      .high_bet          (high_bet),
      .pot               (pot),
      .folded            (folded),
      .round_done        (round_done)
   );

   typedef struct {
      bit new_round;
      int stack1;
      int seat;
      int typ;
      int raise;
      int amt;
      bit done;
      int pot;
      int high;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (act_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("ready_timeout", ok, 1);
   endtask

   task automatic start_round(input int d);
      @(negedge clk);
      dealer_seat = SW'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_action(input vec_t v);
      wait_ready();
      chk("active_seat", active_seat, v.seat);
      act_valid = 1'b1;
      act_type  = 2'(v.typ);
      act_raise = MAX_STACK_W'(v.raise);
      @(negedge clk);
      act_valid = 1'b0;
      chk("make_bet", player_make_bet, (v.amt != 0));
      chk("bet_amount", player_bet_amount, v.amt);
      chk("player_en", player_en, (v.amt != 0) ? (1 << v.seat) : 0);
      @(posedge clk);
      #1 stacks[v.seat] = stacks[v.seat] - v.amt;
      @(negedge clk);
      @(negedge clk);
      chk("round_done", round_done, v.done);
      chk("act_ready", act_ready, !v.done);
      chk("pot", pot, v.pot);
      chk("high_bet", high_bet, v.high);
      $display("action seat=%0d type=%0d raise=%0d amt=%0d pot=%0d high=%0d done=%0b",
               v.seat, v.typ, v.raise, player_bet_amount, pot, high_bet, round_done);
   endtask

   // Offer one action, confirm the strobe in APPLY, then pull reset.
   task automatic reset_mid_apply(input int seat, input int typ, input int raise, input int amt);
      act_valid = 1'b1;
      act_type  = 2'(typ);
      act_raise = MAX_STACK_W'(raise);
      @(negedge clk);
      act_valid = 1'b0;
      chk("rst_pre_make_bet", player_make_bet, 1);
      chk("rst_pre_amount", player_bet_amount, amt);
      chk("rst_pre_en", player_en, 1 << seat);
      reset_n = 1'b0;
      #1;
      chk("rst_make_bet", player_make_bet, 0);
      chk("rst_en", player_en, 0);
      chk("rst_amount", player_bet_amount, 0);
      chk("rst_pot", pot, 0);
      chk("rst_high", high_bet, 0);
      chk("rst_ready", act_ready, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_strobe", player_make_bet, 0);
         chk("post_rst_idle", act_ready, 0);
      end
      $display("reset mid-apply seat=%0d checked", seat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) stacks[i] = 100;

      repeat (2) @(negedge clk);
      chk("reset_ready", act_ready, 0);
      chk("reset_en", player_en, 0);
      chk("reset_make_bet", player_make_bet, 0);
      chk("reset_amount", player_bet_amount, 0);
      chk("reset_seat", active_seat, 0);
      chk("reset_high", high_bet, 0);
      chk("reset_pot", pot, 0);
      chk("reset_folded", folded, 0);
      chk("reset_done", round_done, 0);
      $display("reset state checked");
      @(negedge clk);
      reset_n = 1'b1;

`ifndef BETTING_BLINDS_EN
      // new, stk1, seat, type, raise, amt, done, pot, high
      // Round 1: four checks.
      vecs.push_back('{1, 100, 1, 1,  0,  0, 0,   0,  0});
      vecs.push_back('{0, 100, 2, 1,  0,  0, 0,   0,  0});
      vecs.push_back('{0, 100, 3, 1,  0,  0, 0,   0,  0});
      vecs.push_back('{0, 100, 0, 1,  0,  0, 1,   0,  0});
      // Round 2: raise 20, three calls.
      vecs.push_back('{1, 100, 1, 2, 20, 20, 0,  20, 20});
      vecs.push_back('{0, 100, 2, 1,  0, 20, 0,  40, 20});
      vecs.push_back('{0, 100, 3, 1,  0, 20, 0,  60, 20});
      vecs.push_back('{0, 100, 0, 1,  0, 20, 1,  80, 20});
      // Round 3: raise, re-raise, seat1 calls the difference.
      vecs.push_back('{1, 100, 1, 2, 20, 20, 0,  20, 20});
      vecs.push_back('{0, 100, 2, 2, 30, 50, 0,  70, 50});
      vecs.push_back('{0, 100, 3, 1,  0, 50, 0, 120, 50});
      vecs.push_back('{0, 100, 0, 1,  0, 50, 0, 170, 50});
      vecs.push_back('{0, 100, 1, 1,  0, 30, 1, 200, 50});
      // Round 4: seat1 short stack goes all-in and is skipped.
      vecs.push_back('{1,  15, 1, 1,  0,  0, 0,   0,  0});
      vecs.push_back('{0,  15, 2, 1,  0,  0, 0,   0,  0});
      vecs.push_back('{0,  15, 3, 1,  0,  0, 0,   0,  0});
      vecs.push_back('{0,  15, 0, 2, 40, 40, 0,  40, 40});
      vecs.push_back('{0,  15, 1, 1,  0, 15, 0,  55, 40});
      vecs.push_back('{0,  15, 2, 1,  0, 40, 0,  95, 40});
      vecs.push_back('{0,  15, 3, 1,  0, 40, 1, 135, 40});
      // Round 5: three folds (type 3 counts as fold).
      vecs.push_back('{1, 100, 1, 0,  0,  0, 0,   0,  0});
      vecs.push_back('{0, 100, 2, 3,  0,  0, 0,   0,  0});
      vecs.push_back('{0, 100, 3, 0,  0,  0, 1,   0,  0});

      foreach (vecs[i]) begin
         if (vecs[i].new_round) begin
            for (int s = 0; s < N; s++) stacks[s] = 100;
            stacks[1] = vecs[i].stack1;
            start_round(0);
         end
         do_action(vecs[i]);
      end
      chk("folded_mask", folded, 4'b1110);

      // act_valid while DONE must be ignored.
      act_valid = 1'b1;
      act_type  = 2'd2;
      act_raise = 8'd10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("done_ignore_strobe", player_make_bet, 0);
         chk("done_hold", round_done, 1);
      end
      act_valid = 1'b0;
      $display("act_valid in DONE ignored");

      // start while busy must be ignored.
      for (int s = 0; s < N; s++) stacks[s] = 100;
      start_round(0);
      wait_ready();
      dealer_seat = 2'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_ready", act_ready, 1);
      chk("busy_start_seat", active_seat, 1);
      $display("start while busy ignored seat=%0d", active_seat);

      reset_mid_apply(1, 2, 20, 20);
`else
      start_round(3);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 10; i++) begin
            if (player_make_bet) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         chk("sb_seen", seen, 1);
      end
      chk("sb_en", player_en, 4'b0001);
      chk("sb_amount", player_bet_amount, 5);
      $display("small blind seat0 amt=%0d", player_bet_amount);
      @(negedge clk);
      chk("bb_make_bet", player_make_bet, 1);
      chk("bb_en", player_en, 4'b0010);
      chk("bb_amount", player_bet_amount, 10);
      $display("big blind seat1 amt=%0d", player_bet_amount);
      wait_ready();
      chk("blind_first_seat", active_seat, 2);
      chk("blind_high", high_bet, 10);
      chk("blind_pot", pot, 15);
      $display("blinds posted first=%0d pot=%0d high=%0d", active_seat, pot, high_bet);
      reset_mid_apply(2, 1, 0, 10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/betting_round_ctrl.md
Name: betting_round_ctrl

Overview:
- Sequences one betting round across NUM_PLAYERS player instances.
- Accepts one action at a time from the UI/AI front end, computes the chip amount owed, and drives each player's en/make_bet/bet_amount for one cycle.
- Tracks pot, high bet, folded and all-in seats; declares the round complete.
- Sits between the game FSM (start/done) and the player array.

Parameters:
- NUM_PLAYERS, 4, seats in the game (2..8).
- SEAT_W, $clog2(NUM_PLAYERS), seat index width.
- POT_W, MAX_STACK_W+SEAT_W, pot accumulator width.
- SMALL_BLIND, 5, small blind chips (used only with BLINDS_EN).
- BIG_BLIND, 10, big blind chips (used only with BLINDS_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin round; ignored unless IDLE
- dealer_seat  in  SEAT_W  button position, sampled on start
- act_valid  in  1  action offered
- act_ready  out  1  high only in WAIT_ACT
- act_type  in  2  FOLD=0, CALL=1 (also check), RAISE=2, 3 treated as FOLD
- act_raise  in  MAX_STACK_W  raise-by amount above call
- player_stack  in  NUM_PLAYERS x MAX_STACK_W  current_stack of each player
- player_en  out  NUM_PLAYERS  one-hot enable to the addressed player
- player_make_bet  out  1  one-cycle bet strobe
- player_bet_amount  out  MAX_STACK_W  chips to deduct
- active_seat  out  SEAT_W  seat whose turn it is
- high_bet  out  MAX_STACK_W  highest commitment this round
- pot  out  POT_W  chips committed this round
- folded  out  NUM_PLAYERS  fold mask
- round_done  out  1  level, high in DONE until next start

Behaviour:
- Reset (async): state IDLE, all outputs 0, internal committed[] / acted / allin masks 0.
- States:
  - IDLE: start → INIT.
  - INIT: clear masks and committed; pot=0; high_bet=0; active_seat=dealer+1 mod N → WAIT_ACT.
  - WAIT_ACT: act_ready=1. act_valid&&act_ready → APPLY; the action is latched.
  - APPLY: compute pay, assert player_en[active_seat], player_make_bet=1, player_bet_amount=pay for exactly one cycle → ADVANCE.
  - ADVANCE: evaluate done, else select next seat → WAIT_ACT or DONE.
  - DONE: round_done=1; start → INIT.
- Per-action timing: acceptance to next act_ready = 3 cycles.
- Pay computation, with stack = player_stack[seat]:
  - call_amt = high_bet - committed[seat].
  - FOLD: pay=0, no make_bet strobe, set folded[seat].
  - CALL: pay=min(call_amt, stack).
  - RAISE: pay=min(call_amt+act_raise, stack). If act_raise==0, treat as CALL.
  - If pay==stack and stack>0, set allin[seat]. If pay==0 (check), no strobe.
  - committed[seat]+=pay; pot+=pay, saturating at all ones.
  - If committed[seat]>high_bet: high_bet=committed[seat] and acted mask is reset to only this seat. Otherwise set acted[seat].
  - Short all-in raises still reopen action.
- Done condition, evaluated in ADVANCE:
  - popcount(~folded)==1, or
  - every seat not folded and not all-in has acted and committed==high_bet, or
  - no such seat remains.
- Next seat: first seat after active_seat (mod N wrap) that is not folded and not all-in.
- Boundaries:
  - act_valid outside WAIT_ACT is ignored.
  - start while busy is ignored.
  - reset_n low mid-round aborts to IDLE immediately; no strobe is emitted afterward.
  - player_stack is sampled in APPLY only.

Optional Feature:
- Macro BETTING_BLINDS_EN.
- When defined, INIT inserts states POST_SB then POST_BB.
  - Each state strobes make_bet on seat dealer+1 with min(SMALL_BLIND, stack), then dealer+2 with min(BIG_BLIND, stack).
  - pot, committed and high_bet are updated; neither seat is marked acted.
  - First to act is dealer+3 mod N.
  - If N==2, dealer posts SB and acts first.
- When undefined: no blinds, first to act is dealer+1, high_bet starts at 0.

Decomposition:
- poker_types package gains:
  - action_t enum {ACT_FOLD, ACT_CALL, ACT_RAISE}.
  - bet_state_t enum of FSM states.
  - Reuses MAX_STACK_W.
- One sub-module: next_seat_sel. Combinational rotate-priority search over the eligible mask from a start seat, returning seat and a none_found flag.

Test Plan:
- N=4, dealer=0, all stacks 100, no blinds. Seats 1,2,3,0 each CALL → four checks, no make_bet strobes, round_done after 4th action, pot=0.
- Seat1 RAISE act_raise=20; seats 2,3,0 CALL; seat1 not asked again → 3 strobes of 20, pot=80, high_bet=20, done.
- Seat1 RAISE 20; seat2 RAISE 30; seats 3,0 CALL; seat1 CALL → high_bet=50, seat1 second strobe amount=30, pot=200.
- Seat1 stack 15, seat0 RAISE to 40 → seat1 CALL strobes 15, seat1 marked all-in and skipped thereafter, pot includes 15.
- Seats 1,2,3 FOLD → done after 3rd fold, folded=4'b1110, active_seat never returns to 1.
- BETTING_BLINDS_EN: dealer=3, stacks 100 → strobes seat0 5, seat1 10, first act_ready at seat2, high_bet=10, pot=15. Assert reset_n mid-APPLY → outputs zero next cycle.
